// File: rtl/layer_compositor.sv
// layer_compositor: prioritised colour-keyed layer compositing with palette and blink, 2-cycle pipeline.
module layer_compositor #(
  parameter int          NUM_LAYERS   = 4,
  parameter int          NUM_SRC      = 8,
  parameter logic [23:0] KEY_COLOR    = 24'hFFFFFF,
  parameter logic [23:0] BG_FILL      = 24'h000000,
  parameter int          FLASH_PERIOD = 50_000_000,
  parameter int          FLASH_ON     = 25_000_000
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    pix_valid_in,
  input  logic [9:0]              DrawX_in,
  input  logic [9:0]              DrawY_in,
  input  logic [NUM_SRC*24-1:0]   src_data,
  input  logic [NUM_LAYERS*8-1:0] layer_type,
  input  logic [NUM_LAYERS-1:0]   layer_en,
  input  logic [NUM_LAYERS-1:0]   layer_flash,
  input  logic                    pal_we,
  input  logic [3:0]              pal_addr,
  input  logic [23:0]             pal_data,
  output logic                    pix_valid_out,
  output logic [9:0]              DrawX_out,
  output logic [9:0]              DrawY_out,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B,
  output logic                    flash_phase
);
  localparam int CW = FLASH_PERIOD > 2 ? $clog2(FLASH_PERIOD) : 1;
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  localparam logic [7:0] NS8 = 8'(NUM_SRC);
  logic [CW-1:0] cnt;
  logic [23:0] pal [16];
  logic [23:0] src [NUM_SRC];
  logic [23:0] dec [NUM_LAYERS];
  logic [23:0] col1 [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] op, op1;
  logic [23:0] bg1, rgb;
  logic [9:0] x1, y1;
  logic v1;
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign src[s] = src_data[24*s +: 24];
  end
  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
    logic [7:0] t;
    logic hit_src, hit_pal;
    assign t = layer_type[8*l +: 8];
    assign hit_src = t < NS8;
    assign hit_pal = t[7:4] == 4'h8;
    assign dec[l] = hit_src ? src[t[SW-1:0]] : pal[t[3:0]];
    assign op[l] = layer_en[l] & (hit_src | hit_pal) & (dec[l] != KEY_COLOR) & ~(layer_flash[l] & ~flash_phase);
  end
  always_ff @(posedge Clk)
    if (!Reset) begin
      cnt <= '0;
      flash_phase <= 1'b0;
    end else begin
      cnt <= cnt == CW'(FLASH_PERIOD - 1) ? '0 : cnt + 1'b1;
      flash_phase <= cnt < CW'(FLASH_ON);
    end
  // the palette is read combinationally by stage 1, so a same-cycle write is seen one pixel later
  always_ff @(posedge Clk)
    if (!Reset) for (int i = 0; i < 16; i++) pal[i] <= '0;
    else if (pal_we) pal[pal_addr] <= pal_data;
  always_ff @(posedge Clk)
    if (!Reset) begin
      v1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      bg1 <= '0;
      op1 <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) col1[i] <= '0;
    end else begin
      v1 <= pix_valid_in;
      x1 <= DrawX_in;
      y1 <= DrawY_in;
      bg1 <= src[0];
      op1 <= op;
      for (int i = 0; i < NUM_LAYERS; i++) col1[i] <= dec[i];
    end
  always_comb begin
    rgb = bg1 == KEY_COLOR ? BG_FILL : bg1;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) rgb = op1[i] ? col1[i] : rgb;
  end
  always_ff @(posedge Clk)
    if (!Reset) begin
      pix_valid_out <= 1'b0;
      DrawX_out <= '0;
      DrawY_out <= '0;
      {VGA_R, VGA_G, VGA_B} <= '0;
    end else begin
      pix_valid_out <= v1;
      DrawX_out <= x1;
      DrawY_out <= y1;
      {VGA_R, VGA_G, VGA_B} <= v1 ? rgb : '0;
    end
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed + random scoreboard bench for layer_compositor (blink period 10, on 4).
module tb_layer_compositor;
  localparam logic [23:0] KEY = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;
  localparam int P = 10;
  localparam int ON = 4;
  typedef struct packed {
    logic v;
    logic [9:0] x;
    logic [9:0] y;
    logic [23:0] rgb;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, pv, pal_we, pv_o, fph;
  logic [9:0] x, y, x_o, y_o;
  logic [23:0] src [8];
  logic [191:0] src_data;
  logic [7:0] typ [4];
  logic [31:0] type_bus;
  logic [3:0] en, fl, pal_addr;
  logic [23:0] pal_data;
  logic [7:0] r_o, g_o, b_o;
  for (genvar s = 0; s < 8; s++) begin : g_s
    assign src_data[24*s +: 24] = src[s];
  end
  for (genvar l = 0; l < 4; l++) begin : g_t
    assign type_bus[8*l +: 8] = typ[l];
  end
  layer_compositor #(.FLASH_PERIOD(P), .FLASH_ON(ON)) dut (
    .Clk(clk), .Reset(rst_n), .pix_valid_in(pv), .DrawX_in(x), .DrawY_in(y),
    .src_data(src_data), .layer_type(type_bus), .layer_en(en), .layer_flash(fl),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .pix_valid_out(pv_o), .DrawX_out(x_o), .DrawY_out(y_o),
    .VGA_R(r_o), .VGA_G(g_o), .VGA_B(b_o), .flash_phase(fph));
  exp_t q [$];
  int mc;
  bit mph;
  logic [23:0] mpal [16];
  int n = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model();
    exp_t e;
    logic [23:0] c;
    bit ok, found;
    found = 0;
    e.rgb = src[0] == KEY ? BG : src[0];
    for (int i = 0; i < 4; i++) begin
      ok = 1;
      c = '0;
      if (typ[i] < 8) c = src[typ[i][2:0]];
      else if (typ[i][7:4] == 4'h8) c = mpal[typ[i][3:0]];
      else ok = 0;
      if (!found && en[i] && ok && c != KEY && !(fl[i] && !mph)) begin
        e.rgb = c;
        found = 1;
      end
    end
    e.v = pv;
    e.x = x;
    e.y = y;
    if (!pv) e.rgb = '0;
    return e;
  endfunction
  task automatic step();
    exp_t e;
    q.push_back(model());
    @(posedge clk);
    if (pal_we) mpal[pal_addr] = pal_data;
    mph = mc < ON;
    mc = mc == P - 1 ? 0 : mc + 1;
    #1;
    chk("flash_phase", 32'(fph), 32'(mph));
    if (q.size() > 1) begin
      e = q.pop_front();
      chk("valid", 32'(pv_o), 32'(e.v));
      chk("drawx", 32'(x_o), 32'(e.x));
      chk("drawy", 32'(y_o), 32'(e.y));
      chk("rgb", 32'({r_o, g_o, b_o}), 32'(e.rgb));
    end
    pal_we = 0;
    x = x + 10'd1;
    y = y + 10'd3;
  endtask
  task automatic do_reset();
    rst_n = 0;
    q.delete();
    @(posedge clk);
    mc = 0;
    mph = 0;
    for (int i = 0; i < 16; i++) mpal[i] = '0;
    #1;
    chk("rst_valid", 32'(pv_o), 0);
    chk("rst_xy", 32'({x_o, y_o}), 0);
    chk("rst_rgb", 32'({r_o, g_o, b_o}), 0);
    chk("rst_flash", 32'(fph), 0);
    rst_n = 1;
    q.push_back('0);
  endtask
  initial begin
    int r;
    for (int i = 0; i < 8; i++) src[i] = 24'h101010 * 24'(i + 1);
    for (int i = 0; i < 4; i++) typ[i] = 8'h50;
    en = 4'hF; fl = 0; pv = 1; x = 0; y = 5;
    pal_we = 0; pal_addr = 0; pal_data = 0;
    do_reset();
    typ[0] = 8'h04; src[4] = 24'h123456; typ[1] = 8'h01; src[1] = 24'hABCDEF; en = 4'b0011;
    step();
    src[4] = KEY;
    step();
    for (int i = 0; i < 4; i++) typ[i] = 8'h00;
    src[0] = KEY; en = 4'hF;
    step();
    src[0] = 24'h101010;
    step();
    typ[0] = 8'h83; en = 4'b0001;
    pal_we = 1; pal_addr = 3; pal_data = 24'hB83DBA;
    step();
    step();
    typ[0] = 8'h50; typ[1] = 8'h01; en = 4'b0011;
    step();
    typ[0] = 8'h04; src[4] = 24'h123456; en = 4'b0010;
    step();
    en = 4'b0011;
    pv = 0; step(); pv = 1; step(); step(); pv = 0; step(); pv = 1; step(); step();
    fl = 4'b0001;
    repeat (22) step();
    fl = 0;
    pal_we = 1; pal_addr = 5; pal_data = 24'h445566;
    step();
    do_reset();
    typ[0] = 8'h85; en = 4'b0001;
    step();
    step();
    repeat (60) begin
      for (int i = 0; i < 8; i++) src[i] = $urandom_range(0, 3) == 0 ? KEY : 24'($urandom);
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 10);
        typ[i] = r < 8 ? 8'(r) : r == 8 ? 8'h80 | 8'($urandom_range(0, 15)) : r == 9 ? 8'h50 : 8'hFF;
      end
      en = 4'($urandom); fl = 4'($urandom); pv = $urandom_range(0, 4) != 0;
      pal_we = $urandom_range(0, 1) == 1; pal_addr = 4'($urandom);
      pal_data = $urandom_range(0, 5) == 0 ? KEY : 24'($urandom);
      step();
    end
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
